// File: rtl/lcd_read.sv
// HD44780-style LCD read sequencer: strobes EN with the bus released, samples
// the pad, and optionally re-polls the busy flag until it clears or times out.
module lcd_read #(
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 25,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 50,
  parameter int MAX_POLLS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_sel,
  input  logic       poll,
  input  logic [7:0] lcd_d_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       wr_bus_en,
  output logic [7:0] rdata,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       done_tick,
  output logic       timeout,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ENHI  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAX_B   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_ALL + 1);
  localparam int PW      = $clog2(MAX_POLLS + 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_poll_cnt;
  logic          r_rs;
  logic          r_poll;
  logic [7:0]    r_rdata;
  logic          r_busy_flag;
  logic [6:0]    r_addr_cnt;
  logic          r_done;
  logic          r_timeout;
  logic          w_last;

  // Phase counter runs 0..LEN-1 in each timed state.
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_SETUP: w_last = (r_cnt == CW'(SETUP_CYC - 1));
      S_ENHI:  w_last = (r_cnt == CW'(EN_CYC - 1));
      S_HOLD:  w_last = (r_cnt == CW'(HOLD_CYC - 1));
      S_GAP:   w_last = (r_cnt == CW'(GAP_CYC - 1));
      default: w_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_poll_cnt  <= '0;
      r_rs        <= 1'b0;
      r_poll      <= 1'b0;
      r_rdata     <= 8'h00;
      r_busy_flag <= 1'b0;
      r_addr_cnt  <= 7'h00;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rs       <= rs_sel;
            r_poll     <= poll;
            r_timeout  <= 1'b0;
            r_poll_cnt <= '0;
            r_cnt      <= '0;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_ENHI;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_ENHI: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_rdata <= lcd_d_in;
            if (!r_rs) begin
              r_busy_flag <= lcd_d_in[7];
              r_addr_cnt  <= lcd_d_in[6:0];
            end
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_rs || !r_poll || !r_busy_flag) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_poll_cnt <= r_poll_cnt + PW'(1);
              // This read was the MAX_POLLS-th one still showing busy.
              if (r_poll_cnt == PW'(MAX_POLLS - 1)) begin
                r_timeout <= 1'b1;
                r_done    <= 1'b1;
                r_state   <= S_IDLE;
              end else begin
                r_state <= S_GAP;
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign lcd_rw    = busy;
  assign lcd_rs    = busy & r_rs;
  assign wr_bus_en = ~busy;
  assign lcd_en    = (r_state == S_ENHI);
  assign rdata     = r_rdata;
  assign busy_flag = r_busy_flag;
  assign addr_cnt  = r_addr_cnt;
  assign done_tick = r_done;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_lcd_read.sv
// Directed bench for lcd_read: timing of EN, sampling, polling, timeout,
// asynchronous reset mid-strobe and start handling.
module tb_lcd_read;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rs_sel = 1'b0;
  logic       poll = 1'b0;
  logic [7:0] lcd_d_in = 8'h00;
  logic       lcd_rs, lcd_rw, lcd_en, wr_bus_en;
  logic [7:0] rdata;
  logic       busy_flag;
  logic [6:0] addr_cnt;
  logic       done_tick, timeout, busy;

  int tests = 0;
  int fails = 0;

  lcd_read #(
    .SETUP_CYC(2), .EN_CYC(25), .HOLD_CYC(2), .GAP_CYC(50), .MAX_POLLS(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rs_sel(rs_sel), .poll(poll),
    .lcd_d_in(lcd_d_in), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .wr_bus_en(wr_bus_en), .rdata(rdata), .busy_flag(busy_flag),
    .addr_cnt(addr_cnt), .done_tick(done_tick), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Passive monitor: cycle index, EN pulse bookkeeping and bus-protocol checks.
  int   cyc = 0;
  int   en_pulses = 0;
  int   en_len = 0;
  int   last_en = 0;
  int   done_cnt = 0;
  int   bus_bad = 0;
  int   rise_cyc [0:31];
  logic prev_en = 1'b0;
  logic exp_rs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (lcd_en) begin
      if (!prev_en) begin
        rise_cyc[en_pulses % 32] <= cyc;
        en_pulses <= en_pulses + 1;
        en_len    <= 1;
      end else begin
        en_len <= en_len + 1;
      end
      last_en <= cyc;
    end else begin
      en_len <= 0;
    end
    prev_en <= lcd_en;
    if (done_tick) done_cnt <= done_cnt + 1;
    if (busy) begin
      if (!lcd_rw || wr_bus_en || (lcd_rs !== exp_rs)) bus_bad <= bus_bad + 1;
    end else if (lcd_rw || !wr_bus_en || lcd_rs || lcd_en) begin
      bus_bad <= bus_bad + 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
    $display("[TB] check %s got=0x%0h exp=0x%0h", tag, obs, exp);
  endtask

  task automatic wait_done(input string tag, input int budget, output int dcyc);
    for (int n = 0; n < budget; n++) begin
      step();
      if (done_tick === 1'b1) break;
    end
    dcyc = cyc;
    check({tag, "_done_seen"}, int'(done_tick), 1);
  endtask

  task automatic launch(input logic rs, input logic pl, input logic [7:0] d, output int t0);
    exp_rs   = rs;
    rs_sel   = rs;
    poll     = pl;
    lcd_d_in = d;
    start    = 1'b1;
    t0       = cyc;
    step();
    start = 1'b0;
  endtask

  int t0, dcyc, p0, d0;

  initial begin
    // Reset state
    step(); step();
    check("rst_lcd_en", int'(lcd_en), 0);
    check("rst_wr_bus_en", int'(wr_bus_en), 1);
    check("rst_lcd_rw", int'(lcd_rw), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rdata", int'(rdata), 0);
    rst = 1'b0;
    step();

    // Single data read
    p0 = en_pulses; d0 = done_cnt;
    launch(1'b1, 1'b0, 8'h41, t0);
    check("rd_busy_after_start", int'(busy), 1);
    check("rd_lcd_rs", int'(lcd_rs), 1);
    wait_done("rd", 100, dcyc);
    check("rd_latency", dcyc - t0, 30);
    check("rd_en_first", rise_cyc[p0 % 32] - t0, 3);
    check("rd_en_last", last_en - t0, 27);
    check("rd_en_pulses", en_pulses - p0, 1);
    check("rd_rdata", int'(rdata), 8'h41);
    check("rd_busy_idle", int'(busy), 0);
    step();
    check("rd_done_one_clk", int'(done_tick), 0);
    check("rd_done_count", done_cnt - d0, 1);

    // Busy-flag read without polling
    p0 = en_pulses;
    launch(1'b0, 1'b0, 8'hC5, t0);
    wait_done("bf", 100, dcyc);
    check("bf_busy_flag", int'(busy_flag), 1);
    check("bf_addr_cnt", int'(addr_cnt), 7'h45);
    check("bf_rdata", int'(rdata), 8'hC5);
    check("bf_en_pulses", en_pulses - p0, 1);
    check("bf_timeout", int'(timeout), 0);

    // Poll until busy clears on the fourth read
    p0 = en_pulses;
    launch(1'b0, 1'b1, 8'hFF, t0);
    for (int n = 0; n < 400; n++) begin
      if (en_pulses - p0 == 3 && !lcd_en) break;
      step();
    end
    lcd_d_in = 8'h10;
    wait_done("poll", 400, dcyc);
    check("poll_en_pulses", en_pulses - p0, 4);
    for (int k = 0; k < 3; k++)
      check($sformatf("poll_spacing%0d", k), rise_cyc[(p0 + k + 1) % 32] - rise_cyc[(p0 + k) % 32], 79);
    check("poll_busy_flag", int'(busy_flag), 0);
    check("poll_addr_cnt", int'(addr_cnt), 7'h10);
    check("poll_timeout", int'(timeout), 0);

    // Busy flag stuck: timeout after MAX_POLLS reads
    p0 = en_pulses;
    launch(1'b0, 1'b1, 8'hFF, t0);
    wait_done("to", 600, dcyc);
    check("to_en_pulses", en_pulses - p0, 4);
    check("to_timeout", int'(timeout), 1);
    step(); step(); step();
    check("to_timeout_held", int'(timeout), 1);
    launch(1'b1, 1'b0, 8'h5A, t0);
    check("to_cleared_by_start", int'(timeout), 0);
    wait_done("to_next", 100, dcyc);
    check("to_next_rdata", int'(rdata), 8'h5A);

    // Reset on the 10th EN-high clock
    p0 = en_pulses; d0 = done_cnt;
    launch(1'b0, 1'b0, 8'hC5, t0);
    for (int n = 0; n < 100; n++) begin
      if (en_len == 10) break;
      step();
    end
    check("rstmid_en_len", en_len, 10);
    rst = 1'b1;
    #1;
    check("rstmid_lcd_en", int'(lcd_en), 0);
    check("rstmid_wr_bus_en", int'(wr_bus_en), 1);
    check("rstmid_lcd_rw", int'(lcd_rw), 0);
    check("rstmid_lcd_rs", int'(lcd_rs), 0);
    check("rstmid_rdata", int'(rdata), 0);
    check("rstmid_busy_flag", int'(busy_flag), 0);
    check("rstmid_addr_cnt", int'(addr_cnt), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_done", int'(done_tick), 0);
    step();
    rst = 1'b0;
    for (int n = 0; n < 60; n++) step();
    check("rstmid_no_done", done_cnt - d0, 0);
    check("rstmid_no_more_en", en_pulses - p0, 1);

    // Start re-pulsed during ENHI is ignored; start during done_tick is taken
    p0 = en_pulses; d0 = done_cnt;
    launch(1'b1, 1'b0, 8'h33, t0);
    for (int n = 0; n < 10; n++) step();
    check("ign_in_enhi", int'(lcd_en), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ign", 100, dcyc);
    check("ign_latency", dcyc - t0, 30);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_relaunch_busy", int'(busy), 1);
    wait_done("ign2", 100, dcyc);
    step();
    check("ign_en_pulses", en_pulses - p0, 2);
    check("ign_done_count", done_cnt - d0, 2);

    check("bus_protocol", bus_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
